// File: rtl/tex_dcache_pkg.sv
// tex_dcache_pkg: sizes, response entry type and LFSR
// constants shared by the texture dcache responder.
package tex_dcache_pkg;
  localparam int NUM_REQS   = 4;
  localparam int WORD_SIZE  = 4;
  localparam int ADDR_WIDTH = 10;
  localparam int TAG_WIDTH  = 8;
  localparam int LATENCY    = 2;
  localparam int RSP_DEPTH  = 4;
  localparam int WORD_W     = WORD_SIZE * 8;
  localparam int OCC_W      = $clog2(RSP_DEPTH + 1);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [NUM_REQS-1:0]        tmask;
    logic [NUM_REQS*WORD_W-1:0] data;
    logic [TAG_WIDTH-1:0]       tag;
  } rsp_entry_t;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/tex_dcache_rsp_fifo.sv
// tex_dcache_rsp_fifo: in-order response queue.
// Ports: push/din, pop/dout (head), full, empty, count.
module tex_dcache_rsp_fifo
  import tex_dcache_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  rsp_entry_t    din,
  input  logic          pop,
  output rsp_entry_t    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  rsp_entry_t    mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULLV);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push)
        wp <= (wp == LAST) ? '0 : wp + 1'b1;
      if (do_pop)
        rp <= (rp == LAST) ? '0 : rp + 1'b1;
      unique case (1'b1)
        (do_push && !do_pop): count <= count + 1'b1;
        (do_pop && !do_push): count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= din;
  end
endmodule

// File: rtl/tex_dcache_responder.sv
// tex_dcache_responder: word store serving batched lane
// requests; read batches answer after LATENCY cycles.
// Ports: req_* batch in (req_ready = credit), rsp_* out
// with rsp_ready; reset is async active-low.
// Option TEX_DCACHE_STALL_EN: LFSR stalls req_ready.
module tex_dcache_responder
  import tex_dcache_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS-1:0]             req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]   req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQS*WORD_W-1:0]      req_data,
  input  logic [TAG_WIDTH-1:0]            req_tag,
  output logic                            req_ready,
  output logic                            rsp_valid,
  output logic [NUM_REQS-1:0]             rsp_tmask,
  output logic [NUM_REQS*WORD_W-1:0]      rsp_data,
  output logic [TAG_WIDTH-1:0]            rsp_tag,
  input  logic                            rsp_ready
);
  localparam int WORDS = 1 << ADDR_WIDTH;
  localparam logic [OCC_W:0] DEPTH_V =
    (OCC_W + 1)'(RSP_DEPTH);

  logic [WORD_W-1:0]   store [WORDS];
  logic                accept;
  logic                acc_rd;
  logic                credit;
  logic [NUM_REQS-1:0] rd_mask;
  rsp_entry_t          new_e;
  rsp_entry_t          tail_e;
  rsp_entry_t          head_e;
  logic                tail_v;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OCC_W-1:0]    fifo_cnt;
  logic [OCC_W:0]      pipe_cnt;
  logic [OCC_W:0]      occ;

  assign accept  = reset && (|req_valid) && req_ready;
  assign rd_mask = req_valid & ~req_rw;
  assign acc_rd  = accept && (|rd_mask);

  // reads see the store before this batch's writes land
  always_comb begin
    new_e.tmask = rd_mask;
    new_e.tag   = req_tag;
    new_e.data  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rd_mask[i])
        new_e.data[i*WORD_W +: WORD_W] =
          store[req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // later lanes override earlier ones byte by byte
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        for (int b = 0; b < WORD_SIZE; b++) begin
          if (req_valid[i] && req_rw[i] &&
              req_byteen[i*WORD_SIZE + b])
            store[req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]
                 [b*8 +: 8] <=
              req_data[(i*WORD_SIZE + b)*8 +: 8];
        end
      end
    end
  end

  // the FIFO register is the last delay stage
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign tail_v   = acc_rd;
      assign tail_e   = new_e;
      assign pipe_cnt = '0;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;
      logic [NS-1:0] pv;
      rsp_entry_t    pe [NS];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pv <= '0;
          for (int i = 0; i < NS; i++)
            pe[i] <= '0;
        end else begin
          pv[0] <= acc_rd;
          pe[0] <= new_e;
          for (int i = 1; i < NS; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign tail_v = pv[NS-1];
      assign tail_e = pe[NS-1];

      always_comb begin
        pipe_cnt = '0;
        for (int i = 0; i < NS; i++)
          pipe_cnt = pipe_cnt + (OCC_W + 1)'(pv[i]);
      end
    end
  endgenerate

  tex_dcache_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tail_v),
    .din   (tail_e),
    .pop   (rsp_valid && rsp_ready),
    .dout  (head_e),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign occ    = pipe_cnt + {1'b0, fifo_cnt};
  assign credit = !fifo_full && (occ < DEPTH_V);

  assign rsp_valid = !fifo_empty;
  assign rsp_tmask = rsp_valid ? head_e.tmask : '0;
  assign rsp_data  = rsp_valid ? head_e.data  : '0;
  assign rsp_tag   = rsp_valid ? head_e.tag   : '0;

`ifdef TEX_DCACHE_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= lfsr_next(lfsr);
  end

  assign req_ready = credit && !lfsr[0];
`else
  assign req_ready = credit;
`endif
endmodule

// File: tb/tb_tex_dcache_responder.sv
// tb_tex_dcache_responder: random and directed batches
// checked each cycle against a queue-based model.
`timescale 1ns/1ps
module tb_tex_dcache_responder;
  import tex_dcache_pkg::*;

  localparam int DW = NUM_REQS * WORD_W;

  logic clk = 0;
  logic reset = 1;
  logic [NUM_REQS-1:0]            req_valid = '0;
  logic [NUM_REQS-1:0]            req_rw = '0;
  logic [NUM_REQS*WORD_SIZE-1:0]  req_byteen = '0;
  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr = '0;
  logic [DW-1:0]                  req_data = '0;
  logic [TAG_WIDTH-1:0]           req_tag = '0;
  logic                           req_ready;
  logic                           rsp_valid;
  logic [NUM_REQS-1:0]            rsp_tmask;
  logic [DW-1:0]                  rsp_data;
  logic [TAG_WIDTH-1:0]           rsp_tag;
  logic                           rsp_ready = 0;

  tex_dcache_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_byteen (req_byteen),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_tmask  (rsp_tmask),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_REQS-1:0]  tmask;
    logic [DW-1:0]        data;
    logic [TAG_WIDTH-1:0] tag;
    int                   due;
  } exp_t;

  exp_t              q[$];
  logic [WORD_W-1:0] ref_mem [1 << ADDR_WIDTH];
  int nvec = 0;
  int nerr = 0;
  int edges = 0;
`ifdef TEX_DCACHE_STALL_EN
  localparam logic RST_RDY = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
`endif

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  // model: outstanding responses with their due edge
  always @(negedge clk) begin
    logic ev, rdy, credit;
    logic [NUM_REQS-1:0] rm;
    logic [ADDR_WIDTH-1:0] a;
    exp_t e;
    if (!reset) begin
      q.delete();
      chk("rst_valid", DW'(rsp_valid), 0);
      chk("rst_tmask", DW'(rsp_tmask), 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_tag", DW'(rsp_tag), 0);
      chk("rst_ready", DW'(req_ready), DW'(RST_RDY));
    end else begin
      ev = (q.size() > 0) && (q[0].due <= edges);
      chk("rsp_valid", DW'(rsp_valid), DW'(ev));
      if (ev) begin
        chk("rsp_tmask", DW'(rsp_tmask), DW'(q[0].tmask));
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_tag", DW'(rsp_tag), DW'(q[0].tag));
      end else begin
        chk("idle_tmask", DW'(rsp_tmask), 0);
        chk("idle_data", rsp_data, 0);
        chk("idle_tag", DW'(rsp_tag), 0);
      end
      credit = q.size() < RSP_DEPTH;
`ifdef TEX_DCACHE_STALL_EN
      chk("ready_credit", DW'(req_ready && !credit), 0);
      rdy = req_ready;
`else
      chk("req_ready", DW'(req_ready), DW'(credit));
      rdy = credit;
`endif
      if (ev && rsp_ready)
        void'(q.pop_front());
      if ((|req_valid) && rdy) begin
        rm = req_valid & ~req_rw;
        e.tmask = rm;
        e.tag = req_tag;
        e.data = '0;
        e.due = edges + LATENCY;
        for (int i = 0; i < NUM_REQS; i++) begin
          a = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          if (rm[i])
            e.data[i*WORD_W +: WORD_W] = ref_mem[a];
        end
        for (int i = 0; i < NUM_REQS; i++) begin
          a = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          for (int b = 0; b < WORD_SIZE; b++)
            if (req_valid[i] && req_rw[i] &&
                req_byteen[i*WORD_SIZE + b])
              ref_mem[a][b*8 +: 8] =
                req_data[(i*WORD_SIZE + b)*8 +: 8];
        end
        if (|rm)
          q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_rw = '0;
    req_byteen = '0;
  endtask

  task automatic lane(input int i,
                      input logic v,
                      input logic rw,
                      input logic [WORD_SIZE-1:0] be,
                      input logic [ADDR_WIDTH-1:0] a,
                      input logic [WORD_W-1:0] d);
    req_valid[i] = v;
    req_rw[i] = rw;
    req_byteen[i*WORD_SIZE +: WORD_SIZE] = be;
    req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    req_data[i*WORD_W +: WORD_W] = d;
  endtask

  // hold the driven batch until taken (bounded)
  task automatic issue(output logic ok);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = req_ready;
      tick();
    end
    idle();
  endtask

  task automatic drain();
    int k;
    k = 0;
    rsp_ready = 1;
    while (q.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    chk("drain_timeout", DW'(q.size() == 0), 1);
  endtask

  task automatic rd_lit(input string nm,
                        input logic [ADDR_WIDTH-1:0] a,
                        input logic [TAG_WIDTH-1:0] t,
                        input logic [WORD_W-1:0] w);
    logic ok;
    lane(0, 1, 0, '0, a, '0);
    req_tag = t;
    issue(ok);
    chk({nm, "_acc"}, DW'(ok), 1);
    chk({nm, "_early"}, DW'(rsp_valid), 0);
    tick();
    chk({nm, "_v"}, DW'(rsp_valid), 1);
    chk({nm, "_m"}, DW'(rsp_tmask), 1);
    chk({nm, "_d"}, rsp_data, DW'(w));
    chk({nm, "_t"}, DW'(rsp_tag), DW'(t));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  logic ok;
  int cnt, att, toggles;
  logic prev;

  initial begin
    #1 reset = 0;
    repeat (3) tick();
    reset = 1;
    rsp_ready = 1;

    // fill the whole store so the model knows every word
    for (int a = 0; a < (1 << ADDR_WIDTH); a += NUM_REQS) begin
      for (int i = 0; i < NUM_REQS; i++)
        lane(i, 1, 1, '1, ADDR_WIDTH'(a + i), $urandom);
      issue(ok);
    end

    lane(0, 1, 1, 4'hF, 5, 32'hDEADBEEF);
    issue(ok);
    chk("t1_wr_acc", DW'(ok), 1);
    rd_lit("t1_rd", 5, 8'h3C, 32'hDEADBEEF);
    tick();

    lane(0, 1, 1, 4'hF, 9, 32'h11223344);
    issue(ok);
    lane(0, 1, 1, 4'b0101, 9, 32'hAABBCCDD);
    issue(ok);
    rd_lit("t2_be", 9, 8'h42, 32'h11BB33DD);
    lane(0, 1, 1, 4'hF, 7, 32'h01234567);
    issue(ok);
    lane(0, 1, 0, '0, 7, '0);
    lane(1, 1, 1, 4'hF, 7, 32'hFFFFFFFF);
    req_tag = 8'h51;
    issue(ok);
    tick();
    chk("t2_same_v", DW'(rsp_valid), 1);
    chk("t2_same_m", DW'(rsp_tmask), 1);
    chk("t2_same_d", rsp_data, DW'(32'h01234567));
    rd_lit("t2_after", 7, 8'h52, 32'hFFFFFFFF);
    drain();

    rsp_ready = 0;
    cnt = 0;
`ifdef TEX_DCACHE_STALL_EN
    att = 60;
`else
    att = 6;
`endif
    for (int k = 0; k < att; k++) begin
      lane(0, 1, 0, '0, ADDR_WIDTH'(k), '0);
      req_tag = 8'(8'h80 + k);
      if (req_ready) cnt++;
      tick();
    end
    idle();
    tick();
    chk("t3_accepted", DW'(cnt), 4);
    chk("t3_full", DW'(req_ready), 0);
    rsp_ready = 1;
    chk("t3_not_comb", DW'(req_ready), 0);
    tick();
`ifndef TEX_DCACHE_STALL_EN
    chk("t3_rise", DW'(req_ready), 1);
`endif
    drain();

    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      lane(0, 1, 0, '0, ADDR_WIDTH'(k + 100), '0);
      req_tag = 8'(8'hC0 + k);
      issue(ok);
      chk("t4_rd", DW'(ok), 1);
    end
    lane(1, 1, 1, 4'hF, 20, $urandom);
    issue(ok);
    chk("t4_wr_acc", DW'(ok), 1);
    lane(0, 1, 0, '0, 20, '0);
    req_tag = 8'hC3;
    issue(ok);
    chk("t4_4th", DW'(ok), 1);
    lane(0, 1, 0, '0, 21, '0);
    req_tag = 8'hC4;
    issue(ok);
    chk("t4_5th_blocked", DW'(ok), 0);
    drain();

    lane(0, 1, 0, '0, 5, '0);
    req_tag = 8'h90;
    issue(ok);
    lane(0, 1, 0, '0, 9, '0);
    req_tag = 8'h91;
    issue(ok);
    reset = 0;
    #1;
    chk("t5_valid", DW'(rsp_valid), 0);
    chk("t5_tmask", DW'(rsp_tmask), 0);
    chk("t5_data", rsp_data, 0);
    chk("t5_tag", DW'(rsp_tag), 0);
    chk("t5_ready", DW'(req_ready), DW'(RST_RDY));
    repeat (2) tick();
    reset = 1;
    repeat (6) tick();
    rd_lit("t5_keep5", 5, 8'hA0, 32'hDEADBEEF);
    rd_lit("t5_keep9", 9, 8'hA1, 32'h11BB33DD);
    drain();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQS; i++)
        lane(i, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             WORD_SIZE'($urandom),
             ($urandom_range(0, 3) == 0) ?
               ADDR_WIDTH'($urandom) :
               ADDR_WIDTH'($urandom_range(0, 7)),
             $urandom);
      req_tag = TAG_WIDTH'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle();
    drain();

`ifdef TEX_DCACHE_STALL_EN
    toggles = 0;
    prev = req_ready;
    for (int c = 0; c < 200; c++) begin
      lane(0, 1, 0, '0, ADDR_WIDTH'($urandom), '0);
      req_tag = TAG_WIDTH'(c);
      tick();
      if (req_ready != prev) toggles++;
      prev = req_ready;
    end
    idle();
    drain();
    chk("stall_toggle", DW'(toggles > 0), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tex_dcache_responder.md
# tex_dcache_responder

Memory-side responder for the texture unit's data-cache request interface. It accepts batched multi-lane read/write requests, services them from a local word-addressed backing store, and returns read responses tagged and lane-masked after a fixed latency. Backpressure is applied through a credit-limited response queue. It is the bench and standalone stand-in for the dcache behind the texture sampler.

## Interface
- NUM_REQS, 4, lanes per request batch
- WORD_SIZE, 4, bytes per lane word
- ADDR_WIDTH, 10, word-address width per lane; store depth = 2**ADDR_WIDTH words
- TAG_WIDTH, 8, batch tag width
- LATENCY, 2, cycles from acceptance to response visibility; legal range ≥ 1
- RSP_DEPTH, 4, maximum responses in flight plus queued; legal range ≥ 1
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQS  per-lane request valid
- req_rw  in  NUM_REQS  per-lane 1 = write, 0 = read
- req_byteen  in  NUM_REQS*WORD_SIZE  per-lane byte enables (writes only)
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-lane word address
- req_data  in  NUM_REQS*WORD_SIZE*8  per-lane write data
- req_tag  in  TAG_WIDTH  batch tag
- req_ready  out  1  batch accepted this cycle when high and any req_valid is set
- rsp_valid  out  1  response available
- rsp_tmask  out  NUM_REQS  lanes carrying read data
- rsp_data  out  NUM_REQS*WORD_SIZE*8  per-lane read data; lanes outside rsp_tmask are 0
- rsp_tag  out  TAG_WIDTH  tag of the originating batch
- rsp_ready  in  1  consumer accepts response

## Operation
- Accept when |req_valid && req_ready. The whole batch is taken atomically, with no partial acceptance.
- Writes: every valid lane with rw=1 updates the enabled bytes at the clock edge of acceptance. When several write lanes target the same address, the highest-index lane wins per byte.
- Reads: valid lanes with rw=0 read the store before that batch's writes take effect. A read in the same batch as a write to the same address returns the old data.
- A batch with at least one read lane creates a response with tmask = valid & ~rw. A write-only batch creates no response and consumes no credit.
- Delay pipeline: LATENCY stages, each holding {valid, tmask, data, tag}. The stage output enters the response FIFO.
- Credits: occupied = in-pipeline read batches + FIFO count. req_ready = (occupied < RSP_DEPTH). Write-only batches are also gated by req_ready.
- Response pop happens when rsp_valid && rsp_ready. The FIFO is in-order. The outputs show the FIFO head.
- Memory contents are not reset and are preserved across reset.

## Timing
- A read batch accepted at edge t produces rsp_valid high in the cycle after edge t+LATENCY−1, i.e. LATENCY cycles later. This holds only if the FIFO was empty; otherwise the response is queued behind earlier ones.
- Back-to-back acceptance is allowed every cycle while credits remain.
- Accept and pop in the same cycle leave occupancy unchanged, so req_ready stays high at occupied = RSP_DEPTH−1.
- Full: occupied = RSP_DEPTH forces req_ready = 0. A pop in that cycle raises req_ready on the next cycle, not combinationally.
- rsp_* is stable while rsp_valid && !rsp_ready.
- Reset (asynchronous assert, synchronous deassert expected): rsp_valid=0, rsp_tmask=0, rsp_data=0, rsp_tag=0, req_ready=1 (0 under the stall option when the seeded LFSR bit0=1; see Configuration). Pipeline and FIFO are flushed and occupancy=0. In-flight responses are dropped; writes already committed remain.

## Configuration
- TEX_DCACHE_STALL_EN defined: a 16-bit Fibonacci LFSR is added.
  - Taps 16,14,13,11; reset seed 16'hACE1; it advances every cycle.
  - req_ready = credit term && !lfsr[0].
  - rsp_valid is unaffected.
  - The purpose is to stress texture-unit backpressure.
- Not defined: req_ready is the credit term only, and there is no LFSR logic.

## Structure
- Package tex_dcache_pkg holds:
  - the typedef for a pipeline/FIFO entry {tmask, data, tag};
  - the LFSR seed and tap constants;
  - the occupancy counter width $clog2(RSP_DEPTH+1).
- One sub-module, tex_dcache_rsp_fifo: a parameterised synchronous FIFO (depth RSP_DEPTH, entry type from the package) with push, pop, full, empty and count.
- The top level contains the store, the delay pipeline, the credit logic and the optional LFSR.

## Test plan
- Write lane0 addr 5 data 32'hDEADBEEF byteen 4'hF. Next batch reads lane0 addr 5, tag 8'h3C. Expect rsp_valid exactly 2 cycles after acceptance, rsp_tmask=4'b0001, lane0 data 32'hDEADBEEF, rsp_tag=8'h3C.
- Preload 32'h11223344. Write byteen 4'b0101 data 32'hAABBCCDD. Read back and expect 32'h11BB33DD. In the same batch, lane0 reads addr 7 while lane1 writes addr 7; expect the old value in lane0.
- Hold rsp_ready=0 and issue 6 read batches. Expect exactly 4 accepted and req_ready low afterwards. Release rsp_ready and expect 4 responses in tag order. req_ready rises the cycle after the first pop.
- A write-only batch with rsp_ready=0 and 3 responses queued is accepted, produces no response, and leaves occupancy at 3.
- Assert reset with 2 batches in the pipeline. Expect all outputs 0 and req_ready=1 immediately. After release no stale response appears, and earlier written data reads back intact.
- With TEX_DCACHE_STALL_EN, drive continuous valid read batches and rsp_ready=1 for 200 cycles. Expect req_ready to toggle, every accepted tag to be returned exactly once in order, and no response to be lost.
